l1_tag_lookup: RTL and testbench
================================

# l1_tag_lookup

Tag-lookup stage for the L1 data cache. Sits directly in front of the 256-entry × 19-bit two-port tag SRAM: it accepts load/store requests, reads the tag through the SRAM read port and compares it, then returns hit/miss and victim information. It also owns the SRAM write port for line fills, dirty-bit updates, reset clearing and invalidate-all flushes.

## Interface
- `ADDR_W`, 32: request address width; address is `{tag[16:0], index[7:0], offset[6:0]}`.
- `IDX_W`, 8: tag-array index width (256 sets).
- `TAG_W`, 17: stored tag width.
- Tag word layout (19 bits): bit 18 = valid, bit 17 = dirty, bits [16:0] = tag.
- `clk` in 1: single clock; the tag SRAM's `clk0`/`clk1` are tied to the same net.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: lookup request handshake.
- `req_addr` in ADDR_W: request address.
- `req_write` in 1: request is a store.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_hit` out 1: valid entry with a matching tag.
- `resp_victim_valid`, `resp_victim_dirty` out 1, `resp_victim_tag` out TAG_W: stored entry at the index.
- `resp_index` out IDX_W: index of the lookup.
- `fill_valid` in 1, `fill_ready` out 1, `fill_index` in IDX_W, `fill_tag` in TAG_W: install a line as valid and clean.
- `flush_req` in 1: one-cycle pulse that starts invalidate-all.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `tag_csb0` out 1, `tag_addr0` out IDX_W, `tag_din0` out 19: SRAM write port (chip select active-low).
- `tag_csb1` out 1, `tag_addr1` out IDX_W: SRAM read port.
- `tag_dout1` in 19: SRAM read data.

## Operation
- States: CLEAR, RUN, FLUSH. Reset enters CLEAR with sweep counter = 0.
- CLEAR and FLUSH:
  - Write 19'b0 to index = counter each cycle; counter increments by 1.
  - After index 255 is written: go to RUN. FLUSH also pulses `flush_done`.
  - `req_ready` = 0 and `fill_ready` = 0.
- A flush is accepted in RUN only when no response is outstanding and no dirty update is pending. If accepted it is latched; a `flush_req` seen while blocked is held until these conditions clear.
- Request acceptance (`req_valid && req_ready`):
  - Drive `tag_csb1` = 0 and `tag_addr1` = index.
  - Register the tag, index and write flag into the S1 slot.
- S1 (the cycle after acceptance):
  - `resp_valid` = 1.
  - `resp_hit` = stored valid && stored tag == request tag.
  - Victim fields come from the stored word.
- While `resp_valid && !resp_ready`, `tag_csb1` stays high so `tag_dout1` holds its value.
- `req_ready` = RUN && (!resp_valid || resp_ready) && !pending_update && !latched_flush.
- Dirty update: on response handshake with hit && write && !dirty, write {1,1,tag} at the index.
- Write-port priority: fill > dirty update. A displaced dirty update becomes pending and issues in the next cycle without a fill. `fill_ready` = RUN && !latched_flush.
- A fill writes {1,0,fill_tag} at `fill_index` in the handshake cycle.

## Timing
- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `resp_hit` = 0, all victim/index outputs = 0.
  - `fill_ready` = 0, `flush_done` = 0.
  - `tag_csb0` = 1, `tag_csb1` = 1, all address/data outputs = 0.
- CLEAR lasts 256 cycles after reset release; the first request can be accepted in cycle 257.
- Lookup latency: accepted at edge E, `resp_valid` high after E+1. Back-to-back throughput is 1 per cycle while `resp_ready` = 1.
- A write issued at edge E is visible to reads issued at E+1 or later.
- A flush takes 256 cycles from entering FLUSH; `flush_done` is high for the cycle after the final write.
- If reset asserts mid-flush or mid-lookup, all state is dropped and the block re-enters CLEAR.

## Configuration
- `L1_TAG_BYPASS_EN` defined:
  - A write and a read to the same index issued at the same edge forward the written word into S1 in place of `tag_dout1`.
  - `req_ready` is unaffected.
- Undefined:
  - `req_ready` is forced to 0 in any cycle where the write port is active with `tag_addr0` equal to `req_addr` index.
  - The request is accepted one cycle later.

## Test plan
- Reset release → 256 CLEAR writes of 0 to indices 0..255; `req_ready` first rises in cycle 257.
- Fill tag 0x1ABCD at index 0x12, then load 0x1ABCD_12_00 (`req_addr` = {0x1ABCD, 0x12, 0x00}) → `resp_hit` = 1, `resp_victim_dirty` = 0, one cycle after acceptance.
- Store hit to the same line → `tag_din0` = {1,1,0x1ABCD} at `tag_addr0` = 0x12. A subsequent load reports `resp_victim_dirty` = 1.
- Fill to index 0x40 plus a store hit to index 0x12 completing in the same cycle → fill written first; dirty update written the next cycle; `req_ready` = 0 in between.
- Fill index 0x12 with a new tag while a load to 0x12 is accepted at the same edge:
  - `L1_TAG_BYPASS_EN` defined → response sees the new tag.
  - Undefined → acceptance is delayed one cycle.
- `flush_req` with `resp_valid` high and `resp_ready` = 0 → flush starts only after the response handshake. 256 zero writes follow, `flush_done` pulses once, then all lookups miss.

Source files
------------

// File: rtl/l1_tag_lookup_if.sv
// Request/response, fill and flush signals of the L1 tag-lookup stage.
// master = requester side (cache controller), slave = l1_tag_lookup.
interface l1_tag_lookup_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TAG_W  = 17
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic              resp_victim_valid;
  logic              resp_victim_dirty;
  logic [TAG_W-1:0]  resp_victim_tag;
  logic [IDX_W-1:0]  resp_index;

  logic              fill_valid;
  logic              fill_ready;
  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;

  logic              flush_req;
  logic              flush_done;

  modport master (
    output req_valid, req_addr, req_write, resp_ready,
           fill_valid, fill_index, fill_tag, flush_req,
    input  req_ready, resp_valid, resp_hit, resp_victim_valid,
           resp_victim_dirty, resp_victim_tag, resp_index,
           fill_ready, flush_done
  );

  modport slave (
    input  req_valid, req_addr, req_write, resp_ready,
           fill_valid, fill_index, fill_tag, flush_req,
    output req_ready, resp_valid, resp_hit, resp_victim_valid,
           resp_victim_dirty, resp_victim_tag, resp_index,
           fill_ready, flush_done
  );
endinterface

// File: rtl/l1_tag_lookup.sv
// L1 data-cache tag lookup stage driving a 2-port tag SRAM (clear, lookup, fill, dirty update, flush).
// Optional macro L1_TAG_BYPASS_EN forwards a same-edge write to the same index into the lookup result.
module l1_tag_lookup #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TAG_W  = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  l1_tag_lookup_if.slave     bus,
  output logic               tag_csb0,
  output logic [IDX_W-1:0]   tag_addr0,
  output logic [TAG_W+1:0]   tag_din0,
  output logic               tag_csb1,
  output logic [IDX_W-1:0]   tag_addr1,
  input  logic [TAG_W+1:0]   tag_dout1
);
  localparam int unsigned OFF_W  = ADDR_W - IDX_W - TAG_W;
  localparam int unsigned WORD_W = TAG_W + 2;

  typedef enum logic [1:0] {CLEAR, RUN, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
  logic               s1_write_q, s1_write_d;
  logic               pend_q, pend_d;
  logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
  logic               flush_lat_q, flush_lat_d;
  logic               flush_done_q, flush_done_d;
`ifdef L1_TAG_BYPASS_EN
  logic               fwd_q, fwd_d;
  logic [WORD_W-1:0]  fwd_word_q, fwd_word_d;
`endif

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               unused_off;
  logic [WORD_W-1:0]  stored_word;
  logic               in_run, lookup_hit, resp_hs, dirty_now;
  logic               flush_pend, flush_go, fill_rdy, fill_hs, pend_update;
  logic               wr_en, conflict, req_rdy, accept;
  logic [IDX_W-1:0]   wr_addr;
  logic [WORD_W-1:0]  wr_data;

  assign req_idx    = bus.req_addr[OFF_W +: IDX_W];
  assign req_tag    = bus.req_addr[OFF_W+IDX_W +: TAG_W];
  assign unused_off = ^bus.req_addr[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      s1_idx_q     <= '0;
      s1_write_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_idx_q   <= '0;
      pend_tag_q   <= '0;
      flush_lat_q  <= 1'b0;
      flush_done_q <= 1'b0;
`ifdef L1_TAG_BYPASS_EN
      fwd_q        <= 1'b0;
      fwd_word_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_idx_q     <= s1_idx_d;
      s1_write_q   <= s1_write_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
      pend_tag_q   <= pend_tag_d;
      flush_lat_q  <= flush_lat_d;
      flush_done_q <= flush_done_d;
`ifdef L1_TAG_BYPASS_EN
      fwd_q        <= fwd_d;
      fwd_word_q   <= fwd_word_d;
`endif
    end
  end

  // Output/decode logic: depends only on registered state and inputs.
  always_comb begin
    stored_word = tag_dout1;
`ifdef L1_TAG_BYPASS_EN
    if (fwd_q) stored_word = fwd_word_q;
`endif
    in_run      = (state_q == RUN);
    lookup_hit  = s1_valid_q && stored_word[WORD_W-1] && (stored_word[TAG_W-1:0] == s1_tag_q);
    resp_hs     = s1_valid_q && bus.resp_ready;
    dirty_now   = resp_hs && lookup_hit && s1_write_q && !stored_word[TAG_W];
    flush_pend  = in_run && (bus.flush_req || flush_lat_q);
    fill_rdy    = in_run && !flush_lat_q;
    fill_hs     = bus.fill_valid && fill_rdy;
    // A dirty update displaced by a fill counts as pending already in this cycle.
    pend_update = pend_q || (fill_hs && dirty_now);

    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      CLEAR, FLUSH: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
      end
      RUN: begin
        if (fill_hs) begin
          wr_en   = 1'b1;
          wr_addr = bus.fill_index;
          wr_data = {2'b10, bus.fill_tag};
        end else if (pend_q) begin
          wr_en   = 1'b1;
          wr_addr = pend_idx_q;
          wr_data = {2'b11, pend_tag_q};
        end else if (dirty_now) begin
          wr_en   = 1'b1;
          wr_addr = s1_idx_q;
          wr_data = {2'b11, s1_tag_q};
        end
      end
      default: ;
    endcase
    wr_en = wr_en && rst_n;

`ifdef L1_TAG_BYPASS_EN
    conflict = 1'b0;
`else
    conflict = wr_en && (wr_addr == req_idx);
`endif
    req_rdy  = in_run && (!s1_valid_q || bus.resp_ready) && !pend_update && !flush_pend && !conflict;
    accept   = bus.req_valid && req_rdy;
    flush_go = flush_pend && !s1_valid_q && !pend_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_lat_d  = flush_lat_q;
    flush_done_d = 1'b0;
    s1_valid_d   = s1_valid_q;
    s1_tag_d     = s1_tag_q;
    s1_idx_d     = s1_idx_q;
    s1_write_d   = s1_write_q;
    pend_d       = pend_q;
    pend_idx_d   = pend_idx_q;
    pend_tag_d   = pend_tag_q;
`ifdef L1_TAG_BYPASS_EN
    fwd_d        = fwd_q;
    fwd_word_d   = fwd_word_q;
`endif

    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == '1) state_d = RUN;
      end
      FLUSH: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == '1) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      RUN: begin
        cnt_d       = '0;
        flush_lat_d = flush_pend && !flush_go;
        if (flush_go) state_d = FLUSH;
      end
      default: state_d = CLEAR;
    endcase

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_tag_d   = req_tag;
      s1_idx_d   = req_idx;
      s1_write_d = bus.req_write;
`ifdef L1_TAG_BYPASS_EN
      fwd_d      = wr_en && (wr_addr == req_idx);
      fwd_word_d = wr_data;
`endif
    end else if (resp_hs) begin
      s1_valid_d = 1'b0;
    end

    if (fill_hs && dirty_now) begin
      pend_d     = 1'b1;
      pend_idx_d = s1_idx_q;
      pend_tag_d = s1_tag_q;
    end else if (pend_q && !fill_hs) begin
      pend_d = 1'b0;
    end
  end

  assign bus.req_ready         = req_rdy;
  assign bus.resp_valid        = s1_valid_q;
  assign bus.resp_hit          = lookup_hit;
  assign bus.resp_victim_valid = s1_valid_q && stored_word[WORD_W-1];
  assign bus.resp_victim_dirty = s1_valid_q && stored_word[TAG_W];
  assign bus.resp_victim_tag   = s1_valid_q ? stored_word[TAG_W-1:0] : '0;
  assign bus.resp_index        = s1_idx_q;
  assign bus.fill_ready        = fill_rdy;
  assign bus.flush_done        = flush_done_q;

  assign tag_csb0  = !wr_en;
  assign tag_addr0 = wr_addr;
  assign tag_din0  = wr_data;
  assign tag_csb1  = !accept;
  assign tag_addr1 = accept ? req_idx : '0;
endmodule

// File: tb/tb_l1_tag_lookup.sv
// Directed bench for l1_tag_lookup with a behavioural tag SRAM and a response scoreboard.
module tb_l1_tag_lookup;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned TAG_W  = 17;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_tag_lookup_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  logic        tag_csb0;
  logic [7:0]  tag_addr0;
  logic [18:0] tag_din0;
  logic        tag_csb1;
  logic [7:0]  tag_addr1;
  logic [18:0] tag_dout1 = '0;
  logic [18:0] mem [256] = '{default: 19'h7ffff};

  l1_tag_lookup #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .tag_csb0  (tag_csb0),
    .tag_addr0 (tag_addr0),
    .tag_din0  (tag_din0),
    .tag_csb1  (tag_csb1),
    .tag_addr1 (tag_addr1),
    .tag_dout1 (tag_dout1)
  );

  // Synchronous SRAM: a read at the same edge as a write returns the old word.
  always @(posedge clk) begin
    if (!tag_csb0) mem[tag_addr0] <= tag_din0;
    if (!tag_csb1) tag_dout1 <= mem[tag_addr1];
  end

  typedef struct packed {
    logic        hit;
    logic        vv;
    logic        vd;
    logic [16:0] vtag;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic        last_req_hs, last_fill_hs, last_req_ready, last_resp_valid, last_done;
  logic        last_wr_valid;
  logic [7:0]  last_wr_addr;
  logic [18:0] last_wr_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, score any response handshake, then advance to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    last_req_hs     = bus.req_valid && bus.req_ready;
    last_fill_hs    = bus.fill_valid && bus.fill_ready;
    last_req_ready  = bus.req_ready;
    last_resp_valid = bus.resp_valid;
    last_done       = bus.flush_done;
    last_wr_valid   = !tag_csb0;
    last_wr_addr    = tag_addr0;
    last_wr_data    = tag_din0;
    if (bus.resp_valid && bus.resp_ready) begin
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("resp_hit", bus.resp_hit, e.hit);
        check("resp_victim_valid", bus.resp_victim_valid, e.vv);
        check("resp_victim_dirty", bus.resp_victim_dirty, e.vd);
        check("resp_victim_tag", bus.resp_victim_tag, e.vtag);
        check("resp_index", bus.resp_index, e.idx);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input logic h, input logic vv, input logic vd,
                          input logic [16:0] vt, input logic [7:0] idx);
    exp_t e;
    e.hit = h; e.vv = vv; e.vd = vd; e.vtag = vt; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic [16:0] tag, input logic [7:0] idx, input logic wr,
                        input logic h, input logic vv, input logic vd, input logic [16:0] vt);
    int n;
    push_exp(h, vv, vd, vt, idx);
    bus.req_valid = 1'b1;
    bus.req_addr  = {tag, idx, 7'h3f};
    bus.req_write = wr;
    n = 0;
    do begin tick(); n++; end while (!last_req_hs && n < 20);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    check("req_accept", last_req_hs, 1'b1);
  endtask

  task automatic do_fill(input logic [7:0] idx, input logic [16:0] tag);
    int n;
    bus.fill_valid = 1'b1;
    bus.fill_index = idx;
    bus.fill_tag   = tag;
    n = 0;
    do begin tick(); n++; end while (!last_fill_hs && n < 20);
    bus.fill_valid = 1'b0;
    check("fill_accept", last_fill_hs, 1'b1);
    check("fill_write", {last_wr_valid, last_wr_addr, last_wr_data}, {1'b1, idx, 2'b10, tag});
  endtask

  task automatic run_clear();
    for (int i = 0; i < 256; i++) begin
      tick();
      check("clear_cycle", {last_req_ready, last_wr_valid, last_wr_addr, last_wr_data},
            {1'b0, 1'b1, 8'(i), 19'h0});
    end
    tick();
    check("ready_cycle257", last_req_ready, 1'b1);
  endtask

  task automatic check_reset_outputs();
    #1;
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_resp", {bus.resp_valid, bus.resp_hit, bus.resp_victim_valid,
                       bus.resp_victim_dirty, bus.resp_victim_tag, bus.resp_index}, '0);
    check("rst_fill_ready", bus.fill_ready, 1'b0);
    check("rst_flush_done", bus.flush_done, 1'b0);
    check("rst_wport", {tag_csb0, tag_addr0, tag_din0}, {1'b1, 27'h0});
    check("rst_rport", {tag_csb1, tag_addr1}, {1'b1, 8'h0});
  endtask

  initial begin
    int wcount, bad, dones, last_wr_n, done_n, n;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_write  = 1'b0;
    bus.resp_ready = 1'b1;
    bus.fill_valid = 1'b0;
    bus.fill_index = '0;
    bus.fill_tag   = '0;
    bus.flush_req  = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_clear();

    // Fill then load hit; response one cycle after acceptance.
    do_fill(8'h12, 17'h1abcd);
    do_req(17'h1abcd, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 17'h1abcd);
    tick();
    check("load_latency", last_resp_valid, 1'b1);

    // Store hit marks the line dirty in the handshake cycle.
    do_req(17'h1abcd, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 17'h1abcd);
    tick();
    check("dirty_write", {last_wr_valid, last_wr_addr, last_wr_data}, {1'b1, 8'h12, 2'b11, 17'h1abcd});
    do_req(17'h1abcd, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 17'h1abcd);
    tick();
    do_req(17'h0beef, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 17'h1abcd);
    tick();

    // Fill and dirty update colliding on the write port.
    do_fill(8'h12, 17'h1abcd);
    do_req(17'h1abcd, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 17'h1abcd);
    bus.fill_valid = 1'b1;
    bus.fill_index = 8'h40;
    bus.fill_tag   = 17'h05555;
    tick();
    bus.fill_valid = 1'b0;
    check("collide_fill_hs", last_fill_hs, 1'b1);
    check("collide_fill_first", {last_wr_valid, last_wr_addr, last_wr_data}, {1'b1, 8'h40, 2'b10, 17'h05555});
    check("collide_ready0", last_req_ready, 1'b0);
    tick();
    check("collide_dirty_next", {last_wr_valid, last_wr_addr, last_wr_data}, {1'b1, 8'h12, 2'b11, 17'h1abcd});
    check("collide_ready1", last_req_ready, 1'b0);
    tick();
    check("collide_ready_back", last_req_ready, 1'b1);
    do_req(17'h05555, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 17'h05555);
    do_req(17'h1abcd, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 17'h1abcd);
    tick();

    // Fill and load to the same index at the same edge.
    push_exp(1'b1, 1'b1, 1'b0, 17'h07777, 8'h12);
    bus.fill_valid = 1'b1;
    bus.fill_index = 8'h12;
    bus.fill_tag   = 17'h07777;
    bus.req_valid  = 1'b1;
    bus.req_addr   = {17'h07777, 8'h12, 7'h01};
    bus.req_write  = 1'b0;
    tick();
    bus.fill_valid = 1'b0;
    check("same_edge_fill_hs", last_fill_hs, 1'b1);
`ifdef L1_TAG_BYPASS_EN
    check("same_edge_accept", last_req_hs, 1'b1);
`else
    check("same_edge_accept", last_req_hs, 1'b0);
    tick();
    check("delayed_accept", last_req_hs, 1'b1);
`endif
    bus.req_valid = 1'b0;
    tick();
    check("same_edge_resp", last_resp_valid, 1'b1);

    // Flush requested while a response is stalled.
    bus.resp_ready = 1'b0;
    do_req(17'h05555, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 17'h05555);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_write", last_wr_valid, 1'b0);
      check("stall_ready0", last_req_ready, 1'b0);
      check("stall_resp_held", last_resp_valid, 1'b1);
    end
    bus.resp_ready = 1'b1;
    tick();
    wcount = 0; bad = 0; dones = 0; last_wr_n = -10; done_n = -20;
    for (n = 0; n < 300; n++) begin
      tick();
      if (last_wr_valid) begin
        if (last_wr_addr != 8'(wcount) || last_wr_data != '0) bad++;
        wcount++;
        last_wr_n = n;
      end
      if (last_done) begin
        dones++;
        done_n = n;
      end
    end
    check("flush_write_count", wcount, 256);
    check("flush_write_order", bad, 0);
    check("flush_done_once", dones, 1);
    check("flush_done_timing", done_n, last_wr_n + 1);
    do_req(17'h07777, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
    do_req(17'h05555, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
    tick();

    // Reset in the middle of a flush restarts the clear sweep.
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("midflush_writing", last_wr_valid, 1'b1);
    rst_n = 1'b0;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear();
    do_req(17'h05555, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0);
    tick();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
